// File: rtl/ztft43_pkg.sv
// Shared definitions for the 4.3'' TFT 8080-bus controllers: FSM states,
// panel command words and the job payload latched by the read engine.
package ztft43_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned DUMMY_W = 4;
  localparam int unsigned COUNT_W = 16;
  localparam int unsigned READS_W = 17;

  localparam logic [DATA_W-1:0] CMD_RDID  = 16'hDA00;
  localparam logic [DATA_W-1:0] CMD_RAMRD = 16'h2E00;

  // Opcode the write controller uses to hand a read job to this engine
  localparam logic [3:0] TRIG_READ = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_SET,
    ST_CMD_WRL,
    ST_CMD_WRH,
    ST_RD_L,
    ST_RD_H,
    ST_DONE,
    ST_REL
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0]  cmd;
    logic [DUMMY_W-1:0] dummy;
    logic [READS_W-1:0] total;
  } job_t;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ztft43_reader_if.sv
// 16-bit 8080 parallel panel bus as seen from the controller (master) side.
interface ztft43_reader_if
  import ztft43_pkg::*;
;
  logic              LCD_CS;
  logic              LCD_RS;
  logic              LCD_WR;
  logic              LCD_RD;
  logic [DATA_W-1:0] LCD_DATA_O;
  logic              LCD_DATA_OE;
  logic [DATA_W-1:0] LCD_DATA_I;

  modport master (
    output LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_DATA_O, LCD_DATA_OE,
    input  LCD_DATA_I
  );

  modport slave (
    input  LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_DATA_O, LCD_DATA_OE,
    output LCD_DATA_I
  );
endinterface

// File: rtl/ztft43_strobe_timer.sv
// Load / count-down phase counter shared by every strobe phase; zero_o is
// registered and high once the loaded count has run out.
module ztft43_strobe_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         zero_q, zero_d;

  always_comb begin
    cnt_d  = cnt_q;
    zero_d = zero_q;
    if (load_i) begin
      cnt_d  = load_val_i;
      zero_d = (load_val_i == '0);
    end else if (!zero_q) begin
      cnt_d  = cnt_q - W'(1);
      zero_d = (cnt_q == W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/ztft43_reader.sv
// Read-side engine for the TFT 8080 bus: one command write (RS=0) followed by
// N read strobes (RS=1); leading dummy words are dropped, the rest returned.
module ztft43_reader
  import ztft43_pkg::*;
#(
  parameter int unsigned WR_LOW_CYC  = 1,
  parameter int unsigned WR_HIGH_CYC = 1,
  parameter int unsigned RD_LOW_CYC  = 8,
  parameter int unsigned RD_HIGH_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [DATA_W-1:0]   iCmd,
  input  logic [DUMMY_W-1:0]  iDummy,
  input  logic [COUNT_W-1:0]  iCount,
  output logic [DATA_W-1:0]   oData,
  output logic                oValid,
  output logic                oDone,
  output logic                oBusy,
  ztft43_reader_if.master     lcd
);

  localparam int unsigned MAX_CYC = max4(WR_LOW_CYC, WR_HIGH_CYC, RD_LOW_CYC, RD_HIGH_CYC);
  localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

  state_e             state_q, state_d;
  job_t               job_q, job_d;
  logic [READS_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               cs_q, cs_d, rs_q, rs_d, wr_q, wr_d, rd_q, rd_d, oe_q, oe_d;
  logic               load_c;
  logic [CW-1:0]      load_val_c;
  logic               tmr_zero;
  logic               in_job_c;

  ztft43_strobe_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_c),
    .load_val_i (load_val_c),
    .zero_o     (tmr_zero)
  );

  // Next state; the command write is followed by one RD_H phase so the bus
  // turns around (OE low) before the first read strobe falls.
  always_comb begin
    state_d  = state_q;
    job_d    = job_q;
    rd_cnt_d = rd_cnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    in_job_c = state_q inside {ST_CMD_SET, ST_CMD_WRL, ST_CMD_WRH, ST_RD_L, ST_RD_H};
    case (state_q)
      ST_IDLE: if (en) begin
        job_d.cmd   = iCmd;
        job_d.dummy = iDummy;
        job_d.total = READS_W'(iDummy) + READS_W'(iCount);
        rd_cnt_d    = '0;
        state_d     = ST_CMD_SET;
      end
      ST_CMD_SET: state_d = ST_CMD_WRL;
      ST_CMD_WRL: if (tmr_zero) state_d = ST_CMD_WRH;
      ST_CMD_WRH: if (tmr_zero) state_d = (job_q.total == '0) ? ST_DONE : ST_RD_H;
      ST_RD_L: if (tmr_zero) begin
        state_d  = ST_RD_H;
        rd_cnt_d = rd_cnt_q + READS_W'(1);
        if (rd_cnt_q >= READS_W'(job_q.dummy)) begin
          data_d  = lcd.LCD_DATA_I;
          valid_d = 1'b1;
        end
      end
      ST_RD_H: if (tmr_zero) state_d = (rd_cnt_q == job_q.total) ? ST_DONE : ST_RD_L;
      ST_DONE: state_d = ST_REL;
      ST_REL:  if (!en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Initiator withdrew the request: release the bus, report nothing
    if (in_job_c && !en) begin
      state_d = ST_IDLE;
      data_d  = data_q;
      valid_d = 1'b0;
    end
  end

  // Timer reload on every phase change
  always_comb begin
    load_c     = (state_d != state_q);
    load_val_c = '0;
    case (state_d)
      ST_CMD_WRL: load_val_c = CW'(WR_LOW_CYC - 1);
      ST_CMD_WRH: load_val_c = CW'(WR_HIGH_CYC - 1);
      ST_RD_L:    load_val_c = CW'(RD_LOW_CYC - 1);
      ST_RD_H:    load_val_c = CW'(RD_HIGH_CYC - 1);
      default:    load_val_c = '0;
    endcase
  end

  // Pin and status levels are a registered decode of the next state
  always_comb begin
    busy_d = state_d inside {ST_CMD_SET, ST_CMD_WRL, ST_CMD_WRH, ST_RD_L, ST_RD_H, ST_DONE};
    cs_d   = !(state_d inside {ST_CMD_SET, ST_CMD_WRL, ST_CMD_WRH, ST_RD_L, ST_RD_H});
    rs_d   = !(state_d inside {ST_CMD_SET, ST_CMD_WRL, ST_CMD_WRH});
    oe_d   = state_d inside {ST_CMD_SET, ST_CMD_WRL, ST_CMD_WRH};
    wr_d   = (state_d != ST_CMD_WRL);
    rd_d   = (state_d != ST_RD_L);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      job_q    <= '0;
      rd_cnt_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      cs_q     <= 1'b1;
      rs_q     <= 1'b1;
      wr_q     <= 1'b1;
      rd_q     <= 1'b1;
      oe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      job_q    <= job_d;
      rd_cnt_q <= rd_cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      cs_q     <= cs_d;
      rs_q     <= rs_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      oe_q     <= oe_d;
    end
  end

  assign oData           = data_q;
  assign oValid          = valid_q;
  assign oDone           = done_q;
  assign oBusy           = busy_q;
  assign lcd.LCD_CS      = cs_q;
  assign lcd.LCD_RS      = rs_q;
  assign lcd.LCD_WR      = wr_q;
  assign lcd.LCD_RD      = rd_q;
  assign lcd.LCD_DATA_OE = oe_q;
  assign lcd.LCD_DATA_O  = job_q.cmd;

endmodule

// File: tb/tb_ztft43_reader.sv
// Bench for ztft43_reader: panel bus model returning A000+k per read, a table
// of read jobs, plus hand sequences for hold-en, abort and mid-job reset.
module tb_ztft43_reader;
  import ztft43_pkg::*;

  localparam int RD_LOW  = 8;
  localparam int RD_HIGH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] iCmd = 16'h0;
  logic [3:0]  iDummy = 4'h0;
  logic [15:0] iCount = 16'h0;
  logic [15:0] oData;
  logic        oValid, oDone, oBusy;
  logic [15:0] k = 16'h0;

  ztft43_reader_if lcd();
  assign lcd.LCD_DATA_I = 16'hA000 + k;

  ztft43_reader #(.WR_LOW_CYC(1), .WR_HIGH_CYC(1), .RD_LOW_CYC(RD_LOW), .RD_HIGH_CYC(RD_HIGH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .iCmd   (iCmd),
    .iDummy (iDummy),
    .iCount (iCount),
    .oData  (oData),
    .oValid (oValid),
    .oDone  (oDone),
    .oBusy  (oBusy),
    .lcd    (lcd)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus model / protocol monitor, sampled on the falling clock edge
  logic [15:0] cur_cmd = 16'h0;
  logic [15:0] vq[$];
  int rd_lo = 0, rd_hi = 0, rd_falls = 0, rd_rises = 0, wr_falls = 0, cs_falls = 0, done_cnt = 0;
  logic rd_prev = 1'b1, oe_prev = 1'b0, wr_prev = 1'b1, cs_prev = 1'b1, hi_valid = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!lcd.LCD_RD) chk("oe_while_rd", 32'(lcd.LCD_DATA_OE), 32'd0);
    if (rd_prev && !lcd.LCD_RD) begin
      rd_falls++;
      chk("turnaround", 32'(oe_prev), 32'd0);
      if (hi_valid) chk("rd_high_cycles", rd_hi, RD_HIGH);
      rd_lo = 0;
    end
    if (!lcd.LCD_RD) rd_lo++;
    if (!rd_prev && lcd.LCD_RD && !lcd.LCD_CS) begin
      chk("rd_low_cycles", rd_lo, RD_LOW);
      rd_rises++;
      k = k + 16'd1;
      hi_valid = 1'b1;
      rd_hi = 0;
    end
    if (lcd.LCD_RD && !lcd.LCD_CS) rd_hi++;
    if (lcd.LCD_CS) begin
      hi_valid = 1'b0;
      k = 16'h0;
    end
    if (wr_prev && !lcd.LCD_WR)
      wr_falls++;
    if (!lcd.LCD_WR)
      chk("wr_bus", {14'd0, lcd.LCD_RS, lcd.LCD_DATA_OE, lcd.LCD_DATA_O}, {14'd0, 1'b0, 1'b1, cur_cmd});
    if (cs_prev && !lcd.LCD_CS) cs_falls++;
    if (oValid) vq.push_back(oData);
    if (oDone) done_cnt++;
    rd_prev = lcd.LCD_RD;
    oe_prev = lcd.LCD_DATA_OE;
    wr_prev = lcd.LCD_WR;
    cs_prev = lcd.LCD_CS;
  end

  typedef struct {
    logic [15:0] cmd;
    logic [3:0]  dmy;
    logic [15:0] cnt;
    int          exp_valid;
    logic [15:0] exp_first;
    int          exp_rd;
    int          max_cyc;
    int          hold;
  } vec_t;

  vec_t vecs[6];

  task automatic run_job(input vec_t v);
    int wr0, rr0, d0, cs0, csj, cyc;
    bit seen;
    vq.delete();
    wr0 = wr_falls; rr0 = rd_rises; d0 = done_cnt; csj = cs_falls;
    cur_cmd = v.cmd; iCmd = v.cmd; iDummy = v.dmy; iCount = v.cnt; en = 1'b1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 3000) begin
      @(negedge clk); #1;
      cyc++;
      if (done_cnt != d0) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_latency_ok", 32'(cyc <= v.max_cyc), 32'd1);
    chk("busy_at_done", 32'(oBusy), 32'd1);
    @(negedge clk); #1;
    chk("done_pulse_busy_drop", {30'd0, oDone, oBusy}, 32'd0);
    cs0 = cs_falls;
    if (v.hold > 0) begin
      repeat (v.hold) @(negedge clk);
      #1;
      chk("held_en_no_retrigger", cs_falls, cs0);
      chk("held_en_idle_busy", 32'(oBusy), 32'd0);
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("valid_count", vq.size(), v.exp_valid);
    for (int i = 0; i < vq.size(); i++) chk("rd_data", 32'(vq[i]), 32'(v.exp_first) + 32'(i));
    if (v.exp_valid > 0) chk("odata_hold", 32'(oData), 32'(v.exp_first) + 32'(v.exp_valid - 1));
    chk("rd_pulses", rd_rises - rr0, v.exp_rd);
    chk("wr_pulses", wr_falls - wr0, 1);
    chk("cs_assertions", cs_falls - csj, 1);
    chk("done_count", done_cnt - d0, 1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {15'd0, lcd.LCD_CS, lcd.LCD_RS, lcd.LCD_WR, lcd.LCD_RD, lcd.LCD_DATA_OE,
               oValid, oDone, oBusy, lcd.LCD_DATA_O},
        {15'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
    chk({name, "_odata"}, 32'(oData), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    int rf0, d0, n;
    bit reached;
    //           cmd        dmy   cnt    val first     rd  max  hold
    vecs[0] = '{CMD_RDID,  4'd1, 16'd1, 1, 16'hA001, 2, 30,  0};
    vecs[1] = '{CMD_RAMRD, 4'd1, 16'd4, 4, 16'hA001, 5, 60,  0};
    vecs[2] = '{16'h1234,  4'd0, 16'd0, 0, 16'h0000, 0, 5,   10};
    vecs[3] = '{CMD_RAMRD, 4'd0, 16'd3, 3, 16'hA000, 3, 40,  0};
    vecs[4] = '{16'h0A0B,  4'd3, 16'd2, 2, 16'hA003, 5, 60,  0};
    vecs[5] = '{16'h55AA,  4'd0, 16'd1, 1, 16'hA000, 1, 20,  0};

    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset_state");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    for (int i = 0; i < 6; i++) run_job(vecs[i]);

    // Abort during the third read-low phase of a burst
    vq.delete(); d0 = done_cnt; rf0 = rd_falls;
    cur_cmd = CMD_RAMRD; iCmd = CMD_RAMRD; iDummy = 4'd1; iCount = 16'd4; en = 1'b1;
    n = 0; reached = 1'b0;
    while (!reached && n < 500) begin
      @(negedge clk); #1;
      n++;
      if (rd_falls - rf0 == 3) reached = 1'b1;
    end
    chk("abort_reach_rd3", 32'(reached), 32'd1);
    @(negedge clk); #1;
    en = 1'b0;
    @(negedge clk); #1;
    chk("abort_release", {28'd0, lcd.LCD_RD, lcd.LCD_CS, lcd.LCD_DATA_OE, oBusy}, {28'd0, 4'b1100});
    repeat (40) @(negedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_valid_count", vq.size(), 1);
    if (vq.size() == 1) chk("abort_valid_data", 32'(vq[0]), 32'h0000A001);

    // Asynchronous reset in the middle of a read-low phase
    rf0 = rd_falls;
    cur_cmd = CMD_RAMRD; iCmd = CMD_RAMRD; iDummy = 4'd1; iCount = 16'd4; en = 1'b1;
    n = 0; reached = 1'b0;
    while (!reached && n < 500) begin
      @(negedge clk); #1;
      n++;
      if (rd_falls - rf0 == 2) reached = 1'b1;
    end
    chk("reset_reach_rd", 32'(reached), 32'd1);
    chk("reset_pre_rd_low", 32'(lcd.LCD_RD), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset_async");
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    run_job(vecs[0]);
    run_job(vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
